// File: rtl/mips_operand_fwd_if.sv
// Decode/EX operand-forwarding bus for mips_operand_fwd.
// master: pipeline side that drives the decode slot and the forwarding
// sources. slave: the forwarding/stall block itself.
interface mips_operand_fwd_if;
  // Decode slot
  logic        IdValid;
  logic [4:0]  IdR1Adr;
  logic [4:0]  IdR2Adr;
  logic        IdR1Used;
  logic        IdR2Used;
  logic [31:0] IdR1;
  logic [31:0] IdR2;
  logic [4:0]  IdWAdr;
  logic        IdWE;
  logic        IdMemRead;
  logic        Flush;
  // Forwarding sources
  logic [31:0] ExResult;
  logic [4:0]  MemWAdr;
  logic        MemWE;
  logic [31:0] MemData;
  logic [4:0]  WbWAdr;
  logic        WbWE;
  logic [31:0] WbData;
  // Outputs
  logic        Stall;
  logic        ExValid;
  logic [31:0] ExA;
  logic [31:0] ExB;
  logic [4:0]  ExWAdr;
  logic        ExWE;
  logic        ExMemRead;
  logic [31:0] StallCnt;

  modport master (
    output IdValid, IdR1Adr, IdR2Adr, IdR1Used, IdR2Used, IdR1, IdR2,
           IdWAdr, IdWE, IdMemRead, Flush, ExResult, MemWAdr, MemWE, MemData,
           WbWAdr, WbWE, WbData,
    input  Stall, ExValid, ExA, ExB, ExWAdr, ExWE, ExMemRead, StallCnt
  );

  modport slave (
    input  IdValid, IdR1Adr, IdR2Adr, IdR1Used, IdR2Used, IdR1, IdR2,
           IdWAdr, IdWE, IdMemRead, Flush, ExResult, MemWAdr, MemWE, MemData,
           WbWAdr, WbWE, WbData,
    output Stall, ExValid, ExA, ExB, ExWAdr, ExWE, ExMemRead, StallCnt
  );
endinterface

// File: rtl/mips_operand_fwd.sv
// MIPS ID/EX stage register with operand forwarding and load-use stall.
// Forwarding priority: EX > MEM > (WB) > register file; r0 never forwards.
// Optional feature macro: MIPS_WB_BYPASS_EN adds a write-back bypass term.
// Without it the register file's negedge write provides WB visibility.
module mips_operand_fwd (
  input logic              Clk,
  input logic              Rst,
  mips_operand_fwd_if.slave bus
);

  logic        ex_valid_reg;
  logic [31:0] ex_a_reg;
  logic [31:0] ex_b_reg;
  logic [4:0]  ex_wadr_reg;
  logic        ex_we_reg;
  logic        ex_mem_read_reg;
  logic [31:0] stall_cnt_reg;

  logic [1:0][4:0]  src_adr;
  logic [1:0][31:0] src_rf;
  logic [1:0]       src_used;
  logic [1:0]       src_load_hit;
  logic             hazard;
  logic             stall;
  logic             bubble;

  assign src_adr  = {bus.IdR2Adr, bus.IdR1Adr};
  assign src_rf   = {bus.IdR2, bus.IdR1};
  assign src_used = {bus.IdR2Used, bus.IdR1Used};

  // One forwarding mux per source operand (index 0 = A, 1 = B)
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic [31:0] fwd_val;
    logic        ex_hit;
    logic        mem_hit;

    // Pick the youngest in-flight producer of this source register
    always_comb begin
      fwd_val = src_rf[gi];
      ex_hit  = ex_valid_reg & ex_we_reg & ~ex_mem_read_reg &
                (ex_wadr_reg == src_adr[gi]);
      mem_hit = bus.MemWE & (bus.MemWAdr == src_adr[gi]);
      if (src_adr[gi] == 5'd0) begin
        fwd_val = 32'h0;
      end else if (ex_hit) begin
        fwd_val = bus.ExResult;
      end else if (mem_hit) begin
        fwd_val = bus.MemData;
      end
`ifdef MIPS_WB_BYPASS_EN
      else if (bus.WbWE && (bus.WbWAdr == src_adr[gi])) begin
        fwd_val = bus.WbData;
      end
`endif
    end

    // A load in EX whose result this instruction actually needs
    assign src_load_hit[gi] = src_used[gi] & (ex_wadr_reg == src_adr[gi]);
  end

`ifndef MIPS_WB_BYPASS_EN
  // WB port is unused when the register file handles same-cycle visibility
  logic unused_wb;
  assign unused_wb = ^{bus.WbWAdr, bus.WbWE, bus.WbData};
`endif

  // Load-use hazard: load data is not available until it reaches MEM
  always_comb begin
    hazard = bus.IdValid & ex_valid_reg & ex_mem_read_reg & ex_we_reg &
             (ex_wadr_reg != 5'd0) & (|src_load_hit);
    stall  = hazard & ~bus.Flush;
    bubble = bus.Flush | stall | ~bus.IdValid;
  end

  // ID/EX stage register; reset wins, then any bubble source, then load
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_valid_reg    <= 1'b0;
      ex_a_reg        <= 32'h0;
      ex_b_reg        <= 32'h0;
      ex_wadr_reg     <= 5'd0;
      ex_we_reg       <= 1'b0;
      ex_mem_read_reg <= 1'b0;
    end else if (bubble) begin
      ex_valid_reg    <= 1'b0;
      ex_a_reg        <= 32'h0;
      ex_b_reg        <= 32'h0;
      ex_wadr_reg     <= 5'd0;
      ex_we_reg       <= 1'b0;
      ex_mem_read_reg <= 1'b0;
    end else begin
      ex_valid_reg    <= 1'b1;
      ex_a_reg        <= g_op[0].fwd_val;
      ex_b_reg        <= g_op[1].fwd_val;
      ex_wadr_reg     <= bus.IdWAdr;
      ex_we_reg       <= bus.IdWE;
      ex_mem_read_reg <= bus.IdMemRead;
    end
  end

  // Saturating count of load-use stall cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_reg <= 32'h0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.Stall     = stall;
  assign bus.ExValid   = ex_valid_reg;
  assign bus.ExA       = ex_a_reg;
  assign bus.ExB       = ex_b_reg;
  assign bus.ExWAdr    = ex_wadr_reg;
  assign bus.ExWE      = ex_we_reg;
  assign bus.ExMemRead = ex_mem_read_reg;
  assign bus.StallCnt  = stall_cnt_reg;

endmodule

// File: doc/mips_operand_fwd.md
MIPS_OPERAND_FWD -- requirements
Module: mips_operand_fwd

Interface
REQ-001 SHALL have: Clk  in  1  single clock; all state updates on posedge Clk.
REQ-002 SHALL have: Rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have: IdValid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have: IdR1Adr, IdR2Adr  in  5  source register numbers, driven identically to the register-file read addresses.
REQ-005 SHALL have: IdR1Used, IdR2Used  in  1  instruction actually reads that source.
REQ-006 SHALL have: IdR1, IdR2  in  32  register-file read data.
REQ-007 SHALL have: IdWAdr  in  5, IdWE  in  1, IdMemRead  in  1  decode-stage destination, write enable, load flag.
REQ-008 SHALL have: Flush  in  1  branch/BTB redirect; kills the decode-slot instruction.
REQ-009 SHALL have: ExResult  in  32  ALU result of the instruction currently in EX.
REQ-010 SHALL have: MemWAdr  in  5, MemWE  in  1, MemData  in  32  MEM-stage destination, enable, result (load data for loads).
REQ-011 SHALL have: WbWAdr  in  5, WbWE  in  1, WbData  in  32  write-back port, identical to the register-file write inputs.
REQ-012 SHALL have: Stall  out  1  combinational; upstream holds PC and IF/ID while high.
REQ-013 SHALL have: ExValid  out  1, ExA, ExB  out  32, ExWAdr  out  5, ExWE  out  1, ExMemRead  out  1  registered ID/EX stage.
REQ-014 SHALL have: StallCnt  out  32  registered count of load-use stall cycles.

Function
REQ-015 SHALL select ExA's next value as: ExResult if ExValid&ExWE&!ExMemRead&ExWAdr==IdR1Adr; else MemData if MemWE&MemWAdr==IdR1Adr; else WB term (REQ-031); else IdR1. Priority is EX > MEM > WB > register file.
REQ-016 SHALL select ExB's next value in the same way using IdR2Adr/IdR2.
REQ-017 SHALL never forward for source address 0; operand 0 SHALL load as 32'h0 regardless of IdR1/IdR2.
REQ-018 SHALL compute a hazard as: IdValid & ExValid & ExMemRead & ExWE & ExWAdr!=0 & ((IdR1Used & ExWAdr==IdR1Adr) | (IdR2Used & ExWAdr==IdR2Adr)).
REQ-019 SHALL drive Stall = hazard & !Flush.
REQ-020 When Stall is high, the next cycle SHALL load a bubble: ExValid=0, ExWE=0, ExMemRead=0, ExA=ExB=0, ExWAdr=0.
REQ-021 A load-use hazard SHALL cost exactly one stall cycle; the next cycle, the load is in MEM and its data is forwarded via MemData.
REQ-022 When Flush is high, the next cycle SHALL load a bubble; Flush overrides Stall.
REQ-023 When IdValid=0, the next cycle SHALL load a bubble.
REQ-024 Otherwise, ExValid<=1 and ExWAdr/ExWE/ExMemRead <= IdWAdr/IdWE/IdMemRead, with ExA/ExB from REQ-015/016.
REQ-025 Latency SHALL be one cycle from the decode slot to the EX outputs; there is no backpressure other than Stall.
REQ-026 StallCnt SHALL increment by 1 on each posedge where Stall=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-027 Rst=1 at posedge SHALL clear ExValid, ExA, ExB, ExWAdr, ExWE, ExMemRead and StallCnt to 0.
REQ-028 Rst SHALL override Flush, Stall and all data inputs.
REQ-029 Stall SHALL read 0 while ExValid=0, including directly after reset.
REQ-030 A reset asserted mid-stall SHALL discard the stall; no bubble accounting SHALL carry over.

Configuration
REQ-031 With macro MIPS_WB_BYPASS_EN defined, the WB term SHALL be WbData when WbWE & WbWAdr==source address & source address!=0.
REQ-032 With MIPS_WB_BYPASS_EN undefined, the WB term SHALL be absent and the block SHALL rely on the register file's negedge write for same-cycle visibility; the priority chain becomes EX > MEM > register file.

Verification
REQ-033 Back-to-back ALU: EX writes r3=0x10 (ExResult=0x10), ID reads r3 with IdR1=0x0 -> ExA=0x10 next cycle, Stall=0.
REQ-034 Load-use: EX holds lw r4, ID reads r4 (IdR2Used=1) -> Stall=1 for one cycle, bubble loaded, StallCnt=1; next cycle MemData=0xCAFE gives ExB=0xCAFE.
REQ-035 Priority: EX and MEM both target r5 (ExResult=0x1, MemData=0x2) -> ExA=0x1.
REQ-036 Source r0 with MemWE=1, MemWAdr=0, MemData=0xFFFF -> ExA=0.
REQ-037 Flush during load-use hazard -> Stall=0, bubble loaded, StallCnt unchanged; reset mid-stall -> all outputs 0 next cycle.
REQ-038 With MIPS_WB_BYPASS_EN: WbWE=1, WbWAdr=7, WbData=0x77, IdR1=0x0 -> ExA=0x77; without the macro -> ExA=IdR1.
